x_cal_sweep: RTL and testbench
==============================

# x_cal_sweep

Parametrised calibration sweep controller for the delay-line capture path. On an external trigger, it steps the one-hot tap select of the variable delay line across a programmed index range. At each step it waits for the line to settle, takes several snapshots of the delay-line capture word and accumulates their population count. Each step's result is handed to the serialiser (UART) through a valid/ready handshake, which replaces the fixed-tap, single-snapshot capture used in the first-generation calibration top.

## Interface
- p_taps, 256, number of delay-line taps; width of i_data and o_ctrl
- p_idx_w, $clog2(p_taps), width of tap index
- p_first, 0, first tap index of a sweep; also the idle tap
- p_last, p_taps-1, last tap index of a sweep; p_first <= p_last < p_taps
- p_settle, 16, settle cycles per step; must be >= 1
- p_samples, 16, snapshots accumulated per step; must be >= 1
- p_sum_w, $clog2(p_taps*p_samples+1), width of accumulated ones count

- i_clk  in  1  system clock
- i_nrst  in  1  asynchronous active-low reset
- i_trig  in  1  asynchronous trigger, active-low level (UART rx line); a falling edge starts a sweep
- i_data  in  p_taps  delay-line capture word, registered in i_clk domain
- o_ctrl  out  p_taps  one-hot tap select to variable delay line, bit [idx] set
- o_busy  out  1  sweep in progress
- o_valid  out  1  step result available
- i_ready  in  1  consumer accepts result
- o_idx  out  p_idx_w  tap index of presented result
- o_data  out  p_taps  last snapshot of the step
- o_sum  out  p_sum_w  sum of popcount(i_data) over p_samples snapshots
- o_done  out  1  one-cycle pulse after the final step is accepted

## Operation
- Trigger path: i_trig → p1 → p2 flops, both reset to 1; trig = ~p1 & p2. Only a falling edge triggers; holding i_trig low does not retrigger.
- FSM states: IDLE, SETTLE, CAPTURE, SEND.
- IDLE: o_busy=0, idx=p_first. On trig, idx<=p_first, clear sum, go to SETTLE.
- SETTLE: hold o_ctrl=1<<idx for exactly p_settle cycles, then go to CAPTURE.
- CAPTURE: lasts exactly p_samples cycles. Each cycle sum <= sum + popcount(i_data). o_data <= i_data every cycle, so the final sample is retained. Then go to SEND.
- SEND: o_valid=1. o_idx, o_data and o_sum are stable until the cycle where o_valid & i_ready.
  - On handshake with idx==p_last: go to IDLE and pulse o_done.
  - On handshake otherwise: idx<=idx+1, clear sum, go to SETTLE.
- o_ctrl always equals 1<<idx, registered. It changes only when entering SETTLE or when returning to IDLE (value 1<<p_first).
- trig is ignored in every state other than IDLE. The edge detector keeps running regardless.
- Sum never overflows: p_sum_w covers p_taps*p_samples.

## Timing
- Reset values:
  - o_ctrl = 1<<p_first
  - o_busy, o_valid and o_done = 0
  - o_idx = p_first
  - o_data and o_sum = 0
  - state = IDLE
  - p1 and p2 = 1
- Trigger latency: i_trig low is sampled into p1 at edge N; trig is high during cycle N; state=SETTLE and o_busy=1 after edge N+1.
- Per-step cost with i_ready held high: p_settle + p_samples + 1 cycles, with o_valid high for 1 cycle.
- Sweep length with i_ready held high: (p_last-p_first+1)*(p_settle+p_samples+1) cycles from SETTLE entry to IDLE.
- o_done is high in the first IDLE cycle only. o_busy drops in the same cycle.
- o_valid deasserts on the edge following the handshake.
- Asynchronous reset mid-sweep: everything returns to reset values immediately. No partial result is presented after reset. A new falling edge is required to start again.
- p_first==p_last: single-step sweep, o_done follows the first handshake.

## Test plan
- Reset: assert i_nrst low mid-clock → all outputs at reset values; with p_first=0, o_ctrl=1 with no clock running.
- Sweep with p_taps=8, p_first=2, p_last=4, p_settle=3, p_samples=4, i_data=8'h0F, i_ready=1 → three results:
  - o_idx 2/3/4
  - o_ctrl 8'h04/8'h08/8'h10
  - o_sum=16 each
  - o_valid pulses 8 cycles apart
  - o_done one cycle after the third handshake
- Backpressure: same config, i_ready low for 10 cycles during the first SEND → o_valid, o_idx=2, o_sum=16 and o_ctrl=8'h04 held for 10 cycles; sweep resumes on the handshake.
- Varying data: i_data = 8'h01, 8'h03, 8'h07, 8'hFF over the four CAPTURE cycles → o_sum=14, o_data=8'hFF.
- Retrigger: a second falling edge of i_trig during a sweep, and i_trig held low after the sweep → no restart and exactly one o_done. A new falling edge after the sweep starts a new sweep.
- Reset mid-CAPTURE at idx 3 → o_busy=0, o_valid=0 and o_ctrl=8'h04 immediately. No result appears afterwards until a new trigger.

Source files
------------

// File: rtl/x_cal_sweep.sv
// Calibration sweep controller: steps a one-hot delay-line tap select over an
// index range, accumulates snapshot popcounts per tap and hands each result off.
module x_cal_sweep #(
  parameter int p_taps    = 256,
  parameter int p_idx_w   = $clog2(p_taps),
  parameter int p_first   = 0,
  parameter int p_last    = p_taps - 1,
  parameter int p_settle  = 16,
  parameter int p_samples = 16,
  parameter int p_sum_w   = $clog2(p_taps * p_samples + 1)
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_trig,
  input  logic [p_taps-1:0]  i_data,
  output logic [p_taps-1:0]  o_ctrl,
  output logic               o_busy,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [p_idx_w-1:0] o_idx,
  output logic [p_taps-1:0]  o_data,
  output logic [p_sum_w-1:0] o_sum,
  output logic               o_done
);

  localparam int p_cnt_max = (p_settle > p_samples) ? p_settle : p_samples;
  localparam int p_cnt_w   = (p_cnt_max > 1) ? $clog2(p_cnt_max) : 1;

  localparam logic [p_idx_w-1:0] c_first      = p_idx_w'(p_first);
  localparam logic [p_idx_w-1:0] c_last       = p_idx_w'(p_last);
  localparam logic [p_cnt_w-1:0] c_settle_end = p_cnt_w'(p_settle - 1);
  localparam logic [p_cnt_w-1:0] c_sample_end = p_cnt_w'(p_samples - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SEND    = 2'd3
  } state_e;

  function automatic logic [p_sum_w-1:0] popcount(input logic [p_taps-1:0] v);
    logic [p_sum_w-1:0] n;
    n = '0;
    for (int i = 0; i < p_taps; i++) begin
      n = n + p_sum_w'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [p_taps-1:0] onehot(input logic [p_idx_w-1:0] idx);
    return p_taps'(1'b1) << idx;
  endfunction

  state_e             state_q, state_d;
  logic               p1_q, p2_q;
  logic               trig;
  logic [p_idx_w-1:0] idx_q, idx_d;
  logic [p_cnt_w-1:0] cnt_q, cnt_d;
  logic [p_sum_w-1:0] sum_q, sum_d;
  logic [p_taps-1:0]  data_q, data_d;
  logic [p_taps-1:0]  ctrl_q, ctrl_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  // Trigger line is asynchronous; the two flops double as synchroniser and edge detector.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      p1_q <= 1'b1;
      p2_q <= 1'b1;
    end else begin
      p1_q <= i_trig;
      p2_q <= p1_q;
    end
  end

  assign trig = ~p1_q & p2_q;

  // Next-state and datapath update for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = c_first;
        if (trig) begin
          sum_d   = '0;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == c_settle_end) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + p_cnt_w'(1);
        end
      end
      ST_CAPTURE: begin
        sum_d  = sum_q + popcount(i_data);
        data_d = i_data;
        if (cnt_q == c_sample_end) begin
          cnt_d   = '0;
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q + p_cnt_w'(1);
        end
      end
      ST_SEND: begin
        // Result registers stay frozen until the consumer takes them.
        if (i_ready) begin
          if (idx_q == c_last) begin
            idx_d   = c_first;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + p_idx_w'(1);
            sum_d   = '0;
            state_d = ST_SETTLE;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        idx_d   = c_first;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    ctrl_d  = onehot(idx_d);
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_SEND);
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
      idx_q   <= c_first;
      cnt_q   <= '0;
      sum_q   <= '0;
      data_q  <= '0;
      ctrl_q  <= onehot(c_first);
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign o_ctrl  = ctrl_q;
  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_idx   = idx_q;
  assign o_data  = data_q;
  assign o_sum   = sum_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_x_cal_sweep.sv
// Bench for x_cal_sweep: directed sweep sequence with random capture data
// checked against a snapshot-history model of the accumulated counts.
module tb_x_cal_sweep;

  localparam int P_TAPS   = 8;
  localparam int P_FIRST  = 2;
  localparam int P_LAST   = 4;
  localparam int P_SETTLE = 3;
  localparam int P_SAMP   = 4;

  logic       clk;
  logic       nrst;
  logic       clk_run;
  logic       trig0, ready0;
  logic [7:0] data0;
  logic [7:0] ctrl0, odata0;
  logic       busy0, valid0, done0;
  logic [2:0] idx0;
  logic [5:0] sum0;

  logic       trig1, ready1;
  logic [3:0] data1, ctrl1, odata1;
  logic       busy1, valid1, done1;
  logic [1:0] idx1;
  logic [2:0] sum1;

  int n_cmp = 0;
  int n_err = 0;
  int dmode = 0;
  int done_cnt = 0;
  bit busy_any = 1'b0;
  bit valid_any = 1'b0;
  logic [7:0] hist[$];
  logic [7:0] tbl[4];

  x_cal_sweep #(
    .p_taps(P_TAPS), .p_first(P_FIRST), .p_last(P_LAST),
    .p_settle(P_SETTLE), .p_samples(P_SAMP)
  ) dut0 (
    .i_clk(clk), .i_nrst(nrst), .i_trig(trig0), .i_data(data0),
    .o_ctrl(ctrl0), .o_busy(busy0), .o_valid(valid0), .i_ready(ready0),
    .o_idx(idx0), .o_data(odata0), .o_sum(sum0), .o_done(done0)
  );

  x_cal_sweep #(
    .p_taps(4), .p_first(0), .p_last(0), .p_settle(1), .p_samples(1)
  ) dut1 (
    .i_clk(clk), .i_nrst(nrst), .i_trig(trig1), .i_data(data1),
    .o_ctrl(ctrl1), .o_busy(busy1), .o_valid(valid1), .i_ready(ready1),
    .o_idx(idx1), .o_data(odata1), .o_sum(sum1), .o_done(done1)
  );

  initial begin
    clk = 1'b0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: log the value the DUT samples, then pick the next data word.
  task automatic tick();
    hist.push_back(data0);
    @(posedge clk);
    #1;
    if (done0) done_cnt++;
    if (busy0) busy_any = 1'b1;
    if (valid0) valid_any = 1'b1;
    if (dmode == 0) data0 = 8'($urandom);
    else if (dmode == 1) data0 = 8'h0F;
  endtask

  // Model: a result carries the popcount total of the last P_SAMP sampled words.
  function automatic int exp_sum();
    int s = 0;
    for (int k = hist.size() - P_SAMP; k < hist.size(); k++) s += $countones(hist[k]);
    return s;
  endfunction

  task automatic start_sweep();
    trig0 = 1'b0;
    tick();
    chk("trig_lat_n", busy0, 1'b0);
    tick();
    chk("trig_lat_n1", busy0, 1'b1);
    chk("start_ctrl", ctrl0, 8'h01 << P_FIRST);
    chk("start_idx", idx0, P_FIRST);
    trig0 = 1'b1;
  endtask

  task automatic step(input int idx, input int hold, input bit dir);
    int n;
    int e_sum;
    logic [7:0] e_ctrl;
    logic [7:0] e_data;
    e_ctrl = 8'h01 << idx;
    ready0 = (hold == 0);
    n = 0;
    if (dir) begin
      dmode = 2;
      for (int k = 0; k < P_SETTLE + P_SAMP; k++) begin
        if (k < P_SETTLE) data0 = 8'($urandom);
        else data0 = tbl[k - P_SETTLE];
        tick();
        n++;
      end
      dmode = 0;
    end else begin
      while (valid0 !== 1'b1 && n < 64) begin
        tick();
        n++;
      end
    end
    chk("step_lat", n, P_SETTLE + P_SAMP);
    chk("valid_up", valid0, 1'b1);
    e_sum  = exp_sum();
    e_data = hist[hist.size() - 1];
    chk("res_idx", idx0, idx);
    chk("res_ctrl", ctrl0, e_ctrl);
    chk("res_sum", sum0, e_sum);
    chk("res_data", odata0, e_data);
    chk("res_busy", busy0, 1'b1);
    if (dir) begin
      chk("dir_sum", sum0, 14);
      chk("dir_data", odata0, 8'hFF);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", valid0, 1'b1);
      chk("hold_idx", idx0, idx);
      chk("hold_sum", sum0, e_sum);
      chk("hold_ctrl", ctrl0, e_ctrl);
    end
    ready0 = 1'b1;
    tick();
    chk("valid_drop", valid0, 1'b0);
    if (idx == P_LAST) begin
      chk("done_pulse", done0, 1'b1);
      chk("done_busy", busy0, 1'b0);
      chk("done_ctrl", ctrl0, 8'h01 << P_FIRST);
      chk("done_idx", idx0, P_FIRST);
    end else begin
      chk("next_done", done0, 1'b0);
      chk("next_busy", busy0, 1'b1);
      chk("next_ctrl", ctrl0, 8'h01 << (idx + 1));
    end
  endtask

  initial begin
    int n;
    tbl[0] = 8'h01; tbl[1] = 8'h03; tbl[2] = 8'h07; tbl[3] = 8'hFF;
    clk_run = 1'b0;
    nrst = 1'b1;
    trig0 = 1'b1; ready0 = 1'b1; data0 = 8'h00;
    trig1 = 1'b1; ready1 = 1'b1; data1 = 4'hB;

    // Reset with no clock running.
    #2 nrst = 1'b0;
    #2;
    chk("rst_ctrl0", ctrl0, 8'h04);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_valid0", valid0, 1'b0);
    chk("rst_done0", done0, 1'b0);
    chk("rst_idx0", idx0, P_FIRST);
    chk("rst_data0", odata0, 8'h00);
    chk("rst_sum0", sum0, 6'd0);
    chk("rst_ctrl1", ctrl1, 4'h1);
    chk("rst_busy1", busy1, 1'b0);
    clk_run = 1'b1;
    #2 nrst = 1'b1;
    tick(); tick();

    // Sweep with constant 0x0F data and ready high.
    dmode = 1; data0 = 8'h0F; done_cnt = 0;
    start_sweep();
    for (int i = P_FIRST; i <= P_LAST; i++) begin
      step(i, 0, 1'b0);
      chk("fixed_sum", hist.size() >= P_SAMP ? exp_sum() : -1, 16);
    end
    tick();
    chk("done_once", done0, 1'b0);
    chk("done_cnt_a", done_cnt, 1);

    // Backpressure, directed data, retrigger during and after the sweep.
    dmode = 0; data0 = 8'($urandom); done_cnt = 0;
    start_sweep();
    step(2, 10, 1'b0);
    trig0 = 1'b0;
    step(3, 0, 1'b1);
    step(4, 0, 1'b0);
    busy_any = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("no_retrig_busy", busy_any, 1'b0);
    chk("done_cnt_b", done_cnt, 1);

    // Fresh falling edge restarts; then reset in the middle of capture at idx 3.
    trig0 = 1'b1;
    tick(); tick();
    start_sweep();
    step(2, 0, 1'b0);
    for (int i = 0; i < P_SETTLE + 1; i++) tick();
    chk("pre_rst_idx", idx0, 3);
    #2 nrst = 1'b0;
    #1;
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_valid", valid0, 1'b0);
    chk("mid_rst_ctrl", ctrl0, 8'h04);
    chk("mid_rst_sum", sum0, 6'd0);
    #1 nrst = 1'b1;
    busy_any = 1'b0; valid_any = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("post_rst_valid", valid_any, 1'b0);
    chk("post_rst_busy", busy_any, 1'b0);

    // Single-step sweep on the second instance (first == last).
    trig1 = 1'b0;
    tick(); tick();
    chk("single_busy", busy1, 1'b1);
    n = 0;
    while (valid1 !== 1'b1 && n < 32) begin
      tick();
      n++;
    end
    chk("single_lat", n, 2);
    chk("single_sum", sum1, 3);
    chk("single_data", odata1, 4'hB);
    chk("single_idx", idx1, 0);
    chk("single_ctrl", ctrl1, 4'h1);
    tick();
    chk("single_vdrop", valid1, 1'b0);
    chk("single_done", done1, 1'b1);
    chk("single_idle", busy1, 1'b0);
    tick();
    chk("single_done_end", done1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
